// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: link symbols, word width and FSM states for the serial memory responder.
// Optional write acknowledge state is present when MEM_RESPONDER_WRITE_ACK_EN is defined.
package mem_responder_pkg;

    localparam int WORD_BITS = 16;

    localparam logic [1:0] SYM_IDLE     = 2'b00;
    localparam logic [1:0] SYM_READ     = 2'b01;
    localparam logic [1:0] SYM_WRITE    = 2'b11;
    localparam logic [1:0] SYM_RESERVED = 2'b10;
    localparam logic [1:0] SYM_REPLY    = 2'b01;
    localparam logic [1:0] SYM_ACK      = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RX_ADDR,
        RX_DATA,
        MEM_ACCESS,
        TURNAROUND,
        TX_START,
        TX_DATA
`ifdef MEM_RESPONDER_WRITE_ACK_EN
        ,
        TX_ACK
`endif
    } state_t;

endpackage

// File: rtl/responder_shifter.sv
// responder_shifter: word-wide shift register, LSB-first serial in/out with parallel load.
// Serial data enters at the top so the first symbol ends up in the lowest bits.
module responder_shifter
    import mem_responder_pkg::*;
#(
    parameter int NSHIFT = 2,
    parameter int WIDTH  = WORD_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WIDTH-1:0]  din,
    input  logic              shift,
    input  logic [NSHIFT-1:0] sin,
    output logic [WIDTH-1:0]  q,
    output logic [NSHIFT-1:0] sout
);

    // Parallel capture wins over shifting; shifting moves toward the LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {sin, q[WIDTH-1:NSHIFT]};
        end
    end

    assign sout = q[NSHIFT-1:0];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: far end of the 2-bit CPU link; decodes read/write frames, drives memory, replies.
// Define MEM_RESPONDER_WRITE_ACK_EN to send an ack symbol after each write.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int NSHIFT         = 2,
    parameter int PAYLOAD_CYCLES = 8,
    parameter int RESP_DELAY     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSHIFT-1:0]    in_pins,
    output logic [NSHIFT-1:0]    out_pins,
    output logic                 busy,
    output logic                 protocol_error,
    output logic [WORD_BITS-1:0] mem_addr,
    output logic                 mem_re,
    input  logic [WORD_BITS-1:0] mem_rdata,
    output logic                 mem_we,
    output logic [WORD_BITS-1:0] mem_wdata
);

    localparam logic [2:0] LAST_SYM  = 3'(PAYLOAD_CYCLES - 1);
    localparam logic [2:0] LAST_WAIT = 3'(RESP_DELAY - 1);

    state_t                state, state_d;
    logic   [2:0]          cnt;
    logic                  is_write;
    logic                  last;
    logic                  counting;
    logic   [NSHIFT-1:0]   out_d;
    logic [WORD_BITS-1:0]  addr_sr;
    logic [WORD_BITS-1:0]  reply_q;
    logic   [NSHIFT-1:0]   addr_sout;
    logic   [NSHIFT-1:0]   data_sout;
    logic   [NSHIFT-1:0]   reply_sout;
    logic                  unused_bits;

    assign last     = (cnt == LAST_SYM);
    assign counting = state inside {RX_ADDR, RX_DATA, TURNAROUND, TX_DATA};

    responder_shifter #(.NSHIFT(NSHIFT), .WIDTH(WORD_BITS)) u_addr (
        .clk(clk), .rst(reset),
        .load(1'b0), .din('0),
        .shift(state == RX_ADDR), .sin(in_pins),
        .q(addr_sr), .sout(addr_sout)
    );

    responder_shifter #(.NSHIFT(NSHIFT), .WIDTH(WORD_BITS)) u_wdata (
        .clk(clk), .rst(reset),
        .load(1'b0), .din('0),
        .shift(state == RX_DATA), .sin(in_pins),
        .q(mem_wdata), .sout(data_sout)
    );

    responder_shifter #(.NSHIFT(NSHIFT), .WIDTH(WORD_BITS)) u_reply (
        .clk(clk), .rst(reset),
        .load((state == TURNAROUND) && (cnt == 3'd0)), .din(mem_rdata),
        .shift(state_d == TX_DATA), .sin('0),
        .q(reply_q), .sout(reply_sout)
    );

    assign unused_bits = ^{addr_sr[NSHIFT-1:0], addr_sout, data_sout, reply_q};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Next-state decode; in_pins only matter in IDLE and while receiving.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (in_pins == SYM_READ || in_pins == SYM_WRITE)
                    state_d = RX_ADDR;
            end
            RX_ADDR: begin
                if (last) state_d = is_write ? RX_DATA : MEM_ACCESS;
            end
            RX_DATA: begin
                if (last) state_d = MEM_ACCESS;
            end
            MEM_ACCESS: begin
`ifdef MEM_RESPONDER_WRITE_ACK_EN
                state_d = is_write ? TX_ACK : TURNAROUND;
`else
                state_d = is_write ? IDLE : TURNAROUND;
`endif
            end
            TURNAROUND: begin
                if (cnt == LAST_WAIT) state_d = TX_START;
            end
            TX_START: state_d = TX_DATA;
            TX_DATA: begin
                if (last) state_d = IDLE;
            end
`ifdef MEM_RESPONDER_WRITE_ACK_EN
            TX_ACK: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Strobes, status and the next value for the registered reply pins.
    always_comb begin
        busy           = (state != IDLE);
        protocol_error = (state == IDLE) && (in_pins == SYM_RESERVED);
        mem_re         = (state == MEM_ACCESS) && !is_write;
        mem_we         = (state == MEM_ACCESS) && is_write;
        out_d          = SYM_IDLE;
        case (state_d)
            TX_START: out_d = SYM_REPLY;
            TX_DATA:  out_d = reply_sout;
`ifdef MEM_RESPONDER_WRITE_ACK_EN
            TX_ACK:   out_d = SYM_ACK;
`endif
            default:  out_d = SYM_IDLE;
        endcase
    end

    // Reply pins are registered so each symbol is stable for a full cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) out_pins <= SYM_IDLE;
        else       out_pins <= out_d;
    end

    // Symbol / turnaround counter restarts on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 cnt <= 3'd0;
        else if (state_d != state) cnt <= 3'd0;
        else if (counting)         cnt <= cnt + 3'd1;
    end

    // Frame type is latched from the start symbol.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              is_write <= 1'b0;
        else if (state == IDLE) is_write <= (in_pins == SYM_WRITE);
    end

    // Address output only updates once a full address has arrived.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mem_addr <= '0;
        else if (state == RX_ADDR && last)
            mem_addr <= {in_pins, addr_sr[WORD_BITS-1:NSHIFT]};
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: cycle-indexed expectation tables built from frame timing rules,
// checked every cycle against the DUT, plus literal pins on key cycles.
module tb_mem_responder;

    localparam int D    = 1;
    localparam int MAXC = 256;
`ifdef MEM_RESPONDER_WRITE_ACK_EN
    localparam int ACK = 1;
`else
    localparam int ACK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  in_pins = 2'b00;
    logic [1:0]  out_pins;
    logic        busy, perr, mem_re, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h5A5A;

    mem_responder #(.NSHIFT(2), .PAYLOAD_CYCLES(8), .RESP_DELAY(D)) dut (
        .clk(clk), .reset(rst),
        .in_pins(in_pins), .out_pins(out_pins),
        .busy(busy), .protocol_error(perr),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    logic [1:0]  in_arr [MAXC];
    logic [1:0]  e_out  [MAXC];
    bit          e_busy [MAXC];
    bit          e_re   [MAXC];
    bit          e_we   [MAXC];
    bit          e_perr [MAXC];
    logic [15:0] e_addr [MAXC];
    logic [15:0] e_wdata[MAXC];

    logic [15:0] ram  [int];
    logic [15:0] mmem [int];

    typedef struct { int c; int sig; logic [15:0] v; } lit_t;
    lit_t lits[$];

    int cyc = -1;
    int nvec = 0;
    int nmis = 0;
    int endc = 0;
    int rst_at = -1;

    int beef_syms[8] = '{3, 3, 2, 3, 2, 3, 3, 2};
    int a5c3_syms[8] = '{3, 0, 0, 3, 1, 1, 2, 2};

    task automatic chk(input string nm, input int c,
                       input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
        end
    endtask

    function automatic logic [15:0] dut_sig(input int sig);
        case (sig)
            0: return 16'(out_pins);
            1: return 16'(busy);
            2: return mem_addr;
            3: return 16'(mem_re);
            4: return 16'(mem_we);
            5: return mem_wdata;
            default: return 16'(perr);
        endcase
    endfunction

    function automatic string sname(input int sig);
        case (sig)
            0: return "out_pins";
            1: return "busy";
            2: return "mem_addr";
            3: return "mem_re";
            4: return "mem_we";
            5: return "mem_wdata";
            default: return "protocol_error";
        endcase
    endfunction

    task automatic lit(input int c, input int sig, input logic [15:0] v);
        lits.push_back('{c, sig, v});
    endtask

    task automatic clear_from(input int r);
        for (int c = r; c < MAXC; c++) begin
            in_arr[c] = 2'b00; e_out[c] = 2'b00;
            e_busy[c] = 0; e_re[c] = 0; e_we[c] = 0; e_perr[c] = 0;
            e_addr[c] = 16'h0; e_wdata[c] = 16'h0;
        end
    endtask

    task automatic put_word(input int s, input logic [15:0] w);
        for (int k = 0; k < 8; k++) in_arr[s + k] = w[2*k +: 2];
    endtask

    task automatic sched_read(input int s, input logic [15:0] a,
                              input bit noise, output int nxt);
        logic [15:0] w;
        w = mmem.exists(int'(a)) ? mmem[int'(a)] : 16'h0;
        in_arr[s] = 2'b01;
        put_word(s + 1, a);
        for (int c = s + 1; c <= s + 18 + D; c++) e_busy[c] = 1;
        e_re[s + 9] = 1;
        for (int c = s + 9; c < MAXC; c++) e_addr[c] = a;
        e_out[s + 10 + D] = 2'b01;
        for (int k = 0; k < 8; k++) begin
            e_out[s + 11 + D + k] = w[2*k +: 2];
            if (noise) in_arr[s + 11 + D + k] = 2'((k % 3) + 1);
        end
        nxt = s + 19 + D;
    endtask

    task automatic sched_write(input int s, input logic [15:0] a,
                               input logic [15:0] d, input bit commit,
                               output int nxt);
        in_arr[s] = 2'b11;
        put_word(s + 1, a);
        put_word(s + 9, d);
        for (int c = s + 1; c <= s + 17 + ACK; c++) e_busy[c] = 1;
        e_we[s + 17] = 1;
        e_wdata[s + 17] = d;
        for (int c = s + 9; c < MAXC; c++) e_addr[c] = a;
        if (ACK != 0) e_out[s + 18] = 2'b10;
        if (commit) mmem[int'(a)] = d;
        nxt = s + 18 + ACK;
    endtask

    // Input driver: one symbol per cycle from the stimulus table.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc >= 0 && cyc < MAXC) in_pins = in_arr[cyc];
        end
    end

    // Synchronous memory: write on strobe, read data one cycle after mem_re.
    initial begin
        int a;
        forever begin
            @(negedge clk);
            if (mem_we) ram[int'(mem_addr)] = mem_wdata;
            if (mem_re) begin
                a = int'(mem_addr);
                @(posedge clk);
                #1 mem_rdata = ram.exists(a) ? ram[a] : 16'h0;
                @(posedge clk);
                #1 mem_rdata = 16'h5A5A;
            end
        end
    end

    // Per-cycle compare against the tables and the literal pins.
    initial begin
        int c;
        forever begin
            @(negedge clk);
            c = cyc;
            if (c >= 0 && c < endc) begin
                chk("out_pins", c, 16'(out_pins), 16'(e_out[c]));
                chk("busy", c, 16'(busy), 16'(e_busy[c]));
                chk("protocol_error", c, 16'(perr), 16'(e_perr[c]));
                chk("mem_re", c, 16'(mem_re), 16'(e_re[c]));
                chk("mem_we", c, 16'(mem_we), 16'(e_we[c]));
                chk("mem_addr", c, mem_addr, e_addr[c]);
                if (e_we[c]) chk("mem_wdata", c, mem_wdata, e_wdata[c]);
                foreach (lits[i])
                    if (lits[i].c == c)
                        chk({"lit_", sname(lits[i].sig)}, c,
                            dut_sig(lits[i].sig), lits[i].v);
            end
        end
    end

    // Mid-frame asynchronous reset.
    initial begin
        do begin
            @(posedge clk);
            #2;
        end while (cyc != rst_at && cyc < MAXC);
        if (cyc == rst_at) begin
            rst = 1'b1;
            #1;
            chk("rst_busy", cyc, 16'(busy), 16'h0);
            chk("rst_out_pins", cyc, 16'(out_pins), 16'h0);
            chk("rst_mem_we", cyc, 16'(mem_we), 16'h0);
            chk("rst_mem_re", cyc, 16'(mem_re), 16'h0);
            chk("rst_mem_addr", cyc, mem_addr, 16'h0);
            @(posedge clk);
            #3 rst = 1'b0;
        end
    end

    initial begin
        int s, f, r;
        clear_from(0);
        ram[16'h1234] = 16'hBEEF;  mmem[16'h1234] = 16'hBEEF;
        ram[16'h0010] = 16'h1357;  mmem[16'h0010] = 16'h1357;

        for (int c = 0; c < 2; c++) begin
            lit(c, 1, 16'h0); lit(c, 0, 16'h0); lit(c, 2, 16'h0);
        end

        s = 3;
        sched_read(s, 16'h1234, 0, f);
        lit(s + 9, 3, 16'h1); lit(s + 9, 2, 16'h1234);
        lit(s + 10 + D, 0, 16'h1);
        for (int k = 0; k < 8; k++) lit(s + 11 + D + k, 0, 16'(beef_syms[k]));
        lit(s + 18 + D, 1, 16'h1); lit(s + 19 + D, 1, 16'h0);

        s = f + 2;
        in_arr[s] = 2'b10;
        e_perr[s] = 1;
        lit(s, 6, 16'h1); lit(s + 1, 6, 16'h0); lit(s + 1, 1, 16'h0);

        s = s + 2;
        sched_write(s, 16'h00FF, 16'hA5C3, 1, f);
        lit(s + 17, 4, 16'h1); lit(s + 17, 2, 16'h00FF);
        lit(s + 17, 5, 16'hA5C3);
        lit(s + 18, 0, (ACK != 0) ? 16'h2 : 16'h0);

        s = f;
        sched_read(s, 16'h00FF, 1, f);
        for (int k = 0; k < 8; k++) lit(s + 11 + D + k, 0, 16'(a5c3_syms[k]));

        s = f + 3;
        sched_read(s, 16'h0010, 0, f);
        s = f;
        sched_write(s, 16'h0020, 16'h2468, 1, f);
        lit(s + 17, 5, 16'h2468);
        s = f;
        sched_read(s, 16'h0020, 0, f);

        s = f + 2;
        sched_write(s, 16'h0042, 16'hFFFF, 0, f);
        r = s + 5;
        rst_at = r;
        clear_from(r);
        lit(s + 17, 4, 16'h0);

        s = r + 3;
        sched_read(s, 16'h1234, 0, f);
        lit(s + 10 + D, 0, 16'h1);
        lit(s + 11 + D, 0, 16'h3);
        endc = f + 4;

        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        while (cyc < endc) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
